// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: keypad entry sequencer collecting two decimal operands and an operator for an ALU; define CALC_CHAIN_EN to add the result port and chain results
module calc_entry_fsm #(
  parameter int MAX_DIGITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic [19:0] op_a,
  output logic [19:0] op_b,
  output logic [4:0]  operador,
  output logic        calc_valid,
  output logic        key_drop,
  output logic [2:0]  state
`ifdef CALC_CHAIN_EN
  ,
  input  logic [31:0] result
`endif
);
  typedef enum logic [2:0] {IDLE = 3'd0, ENTER_A = 3'd1, OP_WAIT = 3'd2, ENTER_B = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [19:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0] operador_q, operador_d;
  logic [2:0] cnt_q, cnt_d;
  logic calc_valid_q, calc_valid_d, key_drop_q, key_drop_d;
  logic is_dig, is_eq, full;
  logic [19:0] digit, acc_sat;
  logic [23:0] acc;
  assign is_dig = key_code < 5'd10;
  assign is_eq = key_code == 5'd14;
  assign full = cnt_q == 3'(MAX_DIGITS);
  assign digit = {16'd0, key_code[3:0]};
  // Accumulate into whichever operand is currently being typed; the clamp keeps the 20-bit store within 999999
  assign acc = {4'd0, (state_q == ENTER_B) ? op_b_q : op_a_q} * 24'd10 + {4'd0, digit};
  assign acc_sat = (acc > 24'd999999) ? 20'd999999 : acc[19:0];
`ifdef CALC_CHAIN_EN
  logic [19:0] res_sat;
  assign res_sat = (result > 32'd999999) ? 20'd999999 : result[19:0];
`endif
  // Next-state and output decode; only a valid key changes anything, and the pulses self-clear
  always_comb begin
    state_d = state_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    operador_d = operador_q;
    cnt_d = cnt_q;
    calc_valid_d = 1'b0;
    key_drop_d = 1'b0;
    if (key_valid) begin
      if (key_code == 5'd15) begin
        state_d = IDLE;
        op_a_d = '0;
        op_b_d = '0;
        operador_d = '0;
        cnt_d = '0;
      end else if (key_code[4]) begin
        key_drop_d = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_dig) begin
              op_a_d = digit;
              cnt_d = 3'd1;
              state_d = ENTER_A;
            end else key_drop_d = 1'b1;
          end
          ENTER_A: begin
            if (is_dig) begin
              if (full) key_drop_d = 1'b1;
              else begin
                op_a_d = acc_sat;
                cnt_d = cnt_q + 3'd1;
              end
            end else if (!is_eq) begin
              operador_d = key_code;
              op_b_d = '0;
              state_d = OP_WAIT;
            end else key_drop_d = 1'b1;
          end
          OP_WAIT: begin
            if (is_dig) begin
              op_b_d = digit;
              cnt_d = 3'd1;
              state_d = ENTER_B;
            end else if (!is_eq) operador_d = key_code;
            else key_drop_d = 1'b1;
          end
          ENTER_B: begin
            if (is_dig) begin
              if (full) key_drop_d = 1'b1;
              else begin
                op_b_d = acc_sat;
                cnt_d = cnt_q + 3'd1;
              end
            end else if (is_eq) begin
              calc_valid_d = 1'b1;
              state_d = DONE;
            end else key_drop_d = 1'b1;
          end
          DONE: begin
            if (is_dig) begin
              op_a_d = digit;
              op_b_d = '0;
              operador_d = '0;
              cnt_d = 3'd1;
              state_d = ENTER_A;
            end else if (!is_eq) begin
`ifdef CALC_CHAIN_EN
              op_a_d = res_sat;
              op_b_d = '0;
              operador_d = key_code;
              cnt_d = '0;
              state_d = OP_WAIT;
`else
              key_drop_d = 1'b1;
`endif
            end else key_drop_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      operador_q <= '0;
      cnt_q <= '0;
      calc_valid_q <= 1'b0;
      key_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      operador_q <= operador_d;
      cnt_q <= cnt_d;
      calc_valid_q <= calc_valid_d;
      key_drop_q <= key_drop_d;
    end
  end
  assign op_a = op_a_q;
  assign op_b = op_b_q;
  assign operador = operador_q;
  assign calc_valid = calc_valid_q;
  assign key_drop = key_drop_q;
  assign state = state_q;
endmodule
